// File: rtl/axis_bit_packer.sv
// axis_bit_packer: packs variable-length codes MSB-first into fixed-width words,
// flushing a zero-padded final word tagged with output_last at block end.
module axis_bit_packer #(
    parameter int CODE_WIDTH   = 39,
    parameter int LENGTH_WIDTH = 6,
    parameter int OUTPUT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    input_valid,
    input  logic [CODE_WIDTH-1:0]   input_data,
    input  logic [LENGTH_WIDTH-1:0] input_length,
    input  logic                    input_last,
    output logic                    input_ready,
    output logic                    output_valid,
    output logic [OUTPUT_WIDTH-1:0] output_data,
    output logic                    output_last,
    input  logic                    output_ready
);
    localparam int BW = OUTPUT_WIDTH + CODE_WIDTH - 1;
    localparam int CNT_W = $clog2(BW + 1);
    localparam logic [CNT_W-1:0] BW_C = CNT_W'(BW);
    localparam logic [CNT_W-1:0] OW_C = CNT_W'(OUTPUT_WIDTH);
    localparam logic [LENGTH_WIDTH-1:0] CW_L = LENGTH_WIDTH'(CODE_WIDTH);

    typedef enum logic {FILL, FLUSH} state_t;

    state_t                  state_q, state_d;
    logic [BW-1:0]           buf_q, buf_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    input_ready_q, input_ready_d;
    logic                    output_valid_q, output_valid_d;
    logic                    output_last_q, output_last_d;
    logic [OUTPUT_WIDTH-1:0] output_data_q, output_data_d;
    logic [LENGTH_WIDTH-1:0] len;
    logic [BW-1:0]           code;
    logic                    in_fire, out_fire;

    always_comb begin
        in_fire  = input_valid && input_ready_q;
        out_fire = output_valid_q && output_ready;
        len      = (input_length > CW_L) ? CW_L : input_length;
        code     = BW'(input_data & ({CODE_WIDTH{1'b1}} >> (CW_L - len)));
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        // New bits land directly below the cnt occupied bits of the MSB-aligned buffer
        if (in_fire) begin
            buf_d = buf_q | (code << (BW_C - cnt_q - CNT_W'(len)));
            cnt_d = cnt_q + CNT_W'(len);
            if (input_last) state_d = FLUSH;
        end else if (out_fire) begin
            buf_d = buf_q << OUTPUT_WIDTH;
            cnt_d = (cnt_q > OW_C) ? cnt_q - OW_C : '0;
            if (state_q == FLUSH && cnt_q <= OW_C) state_d = FILL;
        end
        input_ready_d  = (state_d == FILL) && (cnt_d < OW_C);
        output_valid_d = (state_d == FLUSH) || (cnt_d >= OW_C);
        output_data_d  = buf_d[BW-1 -: OUTPUT_WIDTH];
        output_last_d  = (state_d == FLUSH) && (cnt_d <= OW_C);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= FILL;
            buf_q          <= '0;
            cnt_q          <= '0;
            input_ready_q  <= 1'b0;
            output_valid_q <= 1'b0;
            output_data_q  <= '0;
            output_last_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            buf_q          <= buf_d;
            cnt_q          <= cnt_d;
            input_ready_q  <= input_ready_d;
            output_valid_q <= output_valid_d;
            output_data_q  <= output_data_d;
            output_last_q  <= output_last_d;
        end
    end

    assign input_ready  = input_ready_q;
    assign output_valid = output_valid_q;
    assign output_data  = output_data_q;
    assign output_last  = output_last_q;
endmodule

// File: tb/tb_axis_bit_packer.sv
// tb_axis_bit_packer: scoreboard bench; expected words are queued as codes are
// driven and checked as the packer emits them.
module tb_axis_bit_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        input_valid = 1'b0;
    logic [38:0] input_data = '0;
    logic [5:0]  input_length = '0;
    logic        input_last = 1'b0;
    logic        input_ready;
    logic        output_valid;
    logic [31:0] output_data;
    logic        output_last;
    logic        output_ready = 1'b1;

    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    bit          bq[$];
    int          n_checks = 0;
    int          n_fail = 0;

    axis_bit_packer dut (
        .clk(clk), .rst(rst),
        .input_valid(input_valid), .input_data(input_data),
        .input_length(input_length), .input_last(input_last),
        .input_ready(input_ready),
        .output_valid(output_valid), .output_data(output_data),
        .output_last(output_last), .output_ready(output_ready)
    );

    always #5 clk = ~clk;

    // A word transfers on the next rising edge when valid&ready hold at the falling edge
    always @(negedge clk) begin
        if (rst && output_valid && output_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: got data=%h last=%b, expected no word", output_data, output_last);
            end else begin
                mon_e = exp_q.pop_front();
                if ({output_last, output_data} !== mon_e) begin
                    n_fail++;
                    $display("FAIL out_word: got data=%h last=%b, expected data=%h last=%b",
                             output_data, output_last, mon_e[31:0], mon_e[32]);
                end
            end
        end
    end

    task automatic send(input logic [38:0] d, input logic [5:0] l, input logic last);
        int k = 0;
        input_valid = 1'b1;
        input_data = d;
        input_length = l;
        input_last = last;
        @(negedge clk);
        while (!input_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!input_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got input_ready=0, expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        input_valid = 1'b0;
        input_last = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d words still pending, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_code(input logic [38:0] d, input logic [5:0] l, input logic last);
        int n;
        logic [31:0] w;
        n = (l > 6'd39) ? 39 : int'(l);
        for (int i = n - 1; i >= 0; i--) bq.push_back(d[i]);
        while (bq.size() > 32 || (!last && bq.size() == 32)) begin
            for (int i = 0; i < 32; i++) w = {w[30:0], bq.pop_front()};
            exp_q.push_back({1'b0, w});
        end
        if (last) begin
            while (bq.size() < 32) bq.push_back(1'b0);
            for (int i = 0; i < 32; i++) w = {w[30:0], bq.pop_front()};
            exp_q.push_back({1'b1, w});
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({input_ready, output_valid, output_last, output_data} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b valid=%b last=%b data=%h, expected all 0",
                     input_ready, output_valid, output_last, output_data);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (input_ready !== 1'b1 || output_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%b valid=%b, expected ready=1 valid=0", input_ready, output_valid);
        end
    endtask

    task automatic test_nibbles();
        exp_q.push_back({1'b1, 32'h12345678});
        for (int i = 1; i <= 8; i++) send((i == 3) ? 39'hF3 : 39'(i), 6'd4, i == 8);
        drain();
    endtask

    task automatic test_long();
        exp_q.push_back({1'b0, 32'hFFFFFFFF});
        exp_q.push_back({1'b1, 32'hFE000000});
        send({39{1'b1}}, 6'd39, 1'b0);
        send(39'h0, 6'd25, 1'b1);
        drain();
    endtask

    task automatic test_short();
        exp_q.push_back({1'b1, 32'hF8000000});
        send(39'h1F, 6'd5, 1'b1);
        n_checks++;
        if (output_valid !== 1'b1 || output_last !== 1'b1) begin
            n_fail++;
            $display("FAIL short_latency: got valid=%b last=%b one cycle after accept, expected 1 1", output_valid, output_last);
        end
        drain();
    endtask

    task automatic test_empty();
        exp_q.push_back({1'b1, 32'h0});
        send(39'h7F, 6'd0, 1'b1);
        drain();
        n_checks++;
        if (input_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_ready: got input_ready=%b after flush, expected 1", input_ready);
        end
    endtask

    task automatic test_backpressure();
        output_ready = 1'b0;
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        send(39'h55DEADBEEF, 6'd32, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (output_valid !== 1'b1 || output_data !== 32'hDEADBEEF || input_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold: got valid=%b data=%h ready=%b, expected 1 deadbeef 0",
                         output_valid, output_data, input_ready);
            end
        end
        output_ready = 1'b1;
        drain();
        exp_q.push_back({1'b1, 32'h0});
        send(39'h0, 6'd0, 1'b1);
        drain();
    endtask

    task automatic test_reset_mid();
        send(39'h12345, 6'd20, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({input_ready, output_valid, output_last, output_data} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got ready=%b valid=%b last=%b data=%h, expected all 0",
                     input_ready, output_valid, output_last, output_data);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back({1'b1, 32'hA0000000});
        send(39'hA, 6'd4, 1'b1);
        drain();
    endtask

    task automatic test_random();
        logic [38:0] d;
        logic [5:0]  l;
        int          n;
        for (int b = 0; b < 4; b++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                d = 39'({$urandom(), $urandom()});
                l = 6'($urandom_range(0, 45));
                model_code(d, l, i == n - 1);
                send(d, l, i == n - 1);
            end
            drain();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, expected test end");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nibbles();
        test_long();
        test_short();
        test_empty();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
